// File: rtl/roic_sync_stream_gen.sv
// rtl/roic_sync_stream_gen.sv - fixed-rate ROIC word stream source: sync header, channel words, idle gap
module roic_sync_stream_gen #(
    parameter int          NUM_CH   = 256,
    parameter int          HDR_LEN  = 4,
    parameter int          GAP_LEN  = 8,
    parameter logic [7:0]  DATA_TAG = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        hdr_sel,
    input  logic [15:0] sample_data,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic [23:0] tx_data,
    output logic        frame_busy,
    output logic        frame_done,
    output logic        underrun,
    output logic [15:0] frame_cnt
);

    localparam int MAX_LEN_A = (NUM_CH > GAP_LEN) ? NUM_CH : GAP_LEN;
    localparam int MAX_LEN   = (MAX_LEN_A > HDR_LEN) ? MAX_LEN_A : HDR_LEN;
    localparam int CW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [CW-1:0] HDR_LAST  = CW'(HDR_LEN - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(NUM_CH - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_LEN - 1);
    localparam logic [23:0]   IDLE_WORD = {16'h0000, DATA_TAG};
    localparam logic [7:0]    HDR_B8    = 8'hB8;
    localparam logic [7:0]    HDR_F8    = 8'hF8;

    // A tag equal to a sync byte would let channel/idle words mimic the header.
    generate
        if (DATA_TAG == 8'hB8 || DATA_TAG == 8'hF8) begin : g_bad_tag
            $error("roic_sync_stream_gen: DATA_TAG must not be 8'hB8 or 8'hF8");
        end
        if (NUM_CH < 2 || NUM_CH > 4096) begin : g_bad_num_ch
            $error("roic_sync_stream_gen: NUM_CH out of range 2..4096");
        end
        if (HDR_LEN < 1 || HDR_LEN > 15) begin : g_bad_hdr_len
            $error("roic_sync_stream_gen: HDR_LEN out of range 1..15");
        end
        if (GAP_LEN < 1 || GAP_LEN > 255) begin : g_bad_gap_len
            $error("roic_sync_stream_gen: GAP_LEN out of range 1..255");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] word_cnt;
    logic [7:0]    hdr_byte;
    logic          pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            word_cnt     <= '0;
            hdr_byte     <= HDR_B8;
            pending      <= 1'b0;
            tx_data      <= IDLE_WORD;
            sample_ready <= 1'b0;
            frame_busy   <= 1'b0;
            frame_done   <= 1'b0;
            underrun     <= 1'b0;
            frame_cnt    <= 16'h0000;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tx_data <= IDLE_WORD;
                    pending <= 1'b0;
                    if (start) begin
                        state      <= ST_HEADER;
                        word_cnt   <= '0;
                        hdr_byte   <= hdr_sel ? HDR_F8 : HDR_B8;
                        frame_busy <= 1'b1;
                        underrun   <= 1'b0;
                    end
                end

                ST_HEADER: begin
                    tx_data <= {frame_cnt, hdr_byte};
                    if (start) begin
                        pending <= 1'b1;
                    end
                    if (word_cnt == HDR_LAST) begin
                        state        <= ST_DATA;
                        word_cnt     <= '0;
                        sample_ready <= 1'b1;
                    end else begin
                        word_cnt <= word_cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    // The slot is spent even without a sample so frame length never varies.
                    if (sample_valid) begin
                        tx_data <= {sample_data, DATA_TAG};
                    end else begin
                        tx_data  <= IDLE_WORD;
                        underrun <= 1'b1;
                    end
                    if (start) begin
                        pending <= 1'b1;
                    end
                    if (word_cnt == DATA_LAST) begin
                        state        <= ST_GAP;
                        word_cnt     <= '0;
                        sample_ready <= 1'b0;
                    end else begin
                        word_cnt <= word_cnt + 1'b1;
                    end
                end

                ST_GAP: begin
                    tx_data <= IDLE_WORD;
                    if (word_cnt == '0) begin
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 16'd1;
                    end
                    if (word_cnt == GAP_LAST) begin
                        word_cnt <= '0;
                        pending  <= 1'b0;
                        // A start in this last cycle counts as pending rather than being dropped.
                        if (pending || start) begin
                            state    <= ST_HEADER;
                            hdr_byte <= hdr_sel ? HDR_F8 : HDR_B8;
                            underrun <= 1'b0;
                        end else begin
                            state      <= ST_IDLE;
                            frame_busy <= 1'b0;
                        end
                    end else begin
                        word_cnt <= word_cnt + 1'b1;
                        if (start) begin
                            pending <= 1'b1;
                        end
                    end
                end

                default: begin
                    state        <= ST_IDLE;
                    word_cnt     <= '0;
                    tx_data      <= IDLE_WORD;
                    sample_ready <= 1'b0;
                    frame_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/roic_sync_stream_gen.md
Name: roic_sync_stream_gen

Overview:
Generates the 24-bit ROIC-style word stream that the receive path parses. Each frame is HDR_LEN sync-header words (lower byte 0xB8 or 0xF8), then NUM_CH channel words, then GAP_LEN idle words. Channel words are sourced from a valid/ready sample interface. The block serves as the on-chip pattern source for loopback and bring-up of first_channel_detector and the downstream deserialization path. It emits exactly one word per clk, so the stream is fixed-rate.

Parameters:
NUM_CH, 256, channel words per frame (2..4096).
HDR_LEN, 4, sync-header words per frame (1..15).
GAP_LEN, 8, idle words after each frame (1..255).
DATA_TAG, 8'h00, lower byte of channel, idle and fill words. An elaboration-time check rejects 8'hB8 and 8'hF8.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  frame request; level-sampled on each clk edge
hdr_sel  in  1  header byte select: 0 = 0xB8, 1 = 0xF8; captured when start is accepted
sample_data  in  16  channel sample
sample_valid  in  1  sample_data is valid
sample_ready  out  1  high in every DATA-state cycle; a sample transfers on valid && ready at the edge
tx_data  out  24  registered output word
frame_busy  out  1  high in HEADER, DATA and GAP states
frame_done  out  1  1-cycle pulse coincident with the first GAP word on tx_data
underrun  out  1  sticky: a DATA cycle occurred with sample_valid = 0
frame_cnt  out  16  completed-frame counter

Behaviour:
- Reset: state IDLE, tx_data = {16'h0000, DATA_TAG}, sample_ready = 0, frame_busy = 0, frame_done = 0, underrun = 0, frame_cnt = 0, pending start cleared. Asserting rst mid-frame aborts immediately; no partial frame resumes.
- FSM states: IDLE, HEADER, DATA, GAP. One word counter, sized for max(NUM_CH, GAP_LEN, HDR_LEN).
- Every edge registers tx_data from the current state:
  - IDLE and GAP: {16'h0000, DATA_TAG}.
  - HEADER: {frame_cnt, hdr byte}.
  - DATA: {sample_data, DATA_TAG} when sample_valid = 1; otherwise the fill word {16'h0000, DATA_TAG}, with underrun set.
- Timing from a start sampled high in IDLE at edge N:
  - Edge N: state goes to HEADER; tx_data is still idle.
  - Edges N+1 .. N+HDR_LEN: header words.
  - Edges N+HDR_LEN+1 .. N+HDR_LEN+NUM_CH: channel words.
  - Edges N+HDR_LEN+NUM_CH+1 .. +GAP_LEN: idle words.
  - Net latency from start to the first header word is 1 cycle.
- The channel counter advances every DATA cycle regardless of sample_valid, so frame length is fixed. Exactly NUM_CH handshakes occur if the source never stalls. No sample is consumed outside DATA.
- frame_done and frame_cnt update on the edge that registers the first GAP word. frame_cnt wraps 16'hFFFF -> 16'h0000. The header carries the pre-increment count: frame k carries value k.
- start while frame_busy sets a single-deep pending flag; further starts are absorbed. If pending is set at the end of GAP, the next edge goes to HEADER, giving back-to-back frames with exactly GAP_LEN idle words between them. hdr_sel is captured at that transition.
- If start is high in the final GAP cycle, it is treated as pending; it is not lost and not double-counted.
- underrun clears only when a start is accepted into HEADER. If the start is accepted and an underrun occurs on the same edge, set has priority.
- Lower byte 0xB8/0xF8 appears only in HEADER words. Any HDR_LEN >= 4 frame therefore triggers the 4-in-a-row detector exactly once per frame when HDR_LEN is 4..7. Note the detector's counter resets after 4 matches, so HDR_LEN = 8 yields 2 pulses.

Test Plan:
1. NUM_CH=8, HDR_LEN=4, GAP_LEN=3, hdr_sel=0, source always valid with data 16'h1000+i; one start -> tx_data sequence is 000000, 0000B8 x4, 1000_00 .. 1007_00, 000000 x3. frame_done pulses once; frame_cnt = 1; underrun = 0.
2. Same, but a second start is asserted mid-DATA with hdr_sel=1 -> second frame starts exactly 3 idle words after the first. Its header is 0001F8 x4; frame_cnt = 2.
3. sample_valid low for channels 2 and 5 -> those words are 0000_00, the other 6 carry data, the frame is still 8 words, underrun = 1. The next start clears underrun.
4. Loopback: tx_data into first_channel_detector over 3 frames -> exactly 3 first_sample_pulse. Word 0 of each frame's channel data aligns with word_data_out per the detector's 3-cycle latency.
5. rst asserted on the 3rd DATA word -> tx_data = 000000, frame_busy = 0, frame_cnt = 0 immediately. The next start produces a header with upper 16 bits 0000.
6. Force frame_cnt to 16'hFFFF, run one frame -> header shows FFFF; after frame_done, frame_cnt = 0000.
